// File: rtl/mat_acc_core.sv
// Memory-mapped int8 NxN matrix-multiply engine: operand banks A/B, int32 result bank C, CTRL/STATUS.
// Optional macro ACC_IRQ_EN adds the irq_o port and a stored CTRL.irq_en bit.
module mat_acc_core #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      en_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef ACC_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam int NN    = N * N;
    localparam int NW    = (NN + 3) / 4;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = $clog2(N);
    localparam int EW    = $clog2(NN);

    // Word-address bases of the operand and result banks.
    localparam logic [31:0] A_BASE = 32'h40;
    localparam logic [31:0] B_BASE = 32'h80;
    localparam logic [31:0] C_BASE = 32'h100;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_STORE, S_DONE} state_t;

    state_t state_q, state_d;

    logic signed [7:0]  a_mem [NN];
    logic signed [7:0]  b_mem [NN];
    logic signed [31:0] c_mem [NN];

    logic [IW-1:0]      i_q, j_q, k_q;
    logic signed [31:0] acc_q;
    logic               done_q;
    logic               busy;
    logic [DATA_WIDTH-1:0] rdata_q, rd_next, ctrl_rd;

    logic [31:0] wa, a_off, b_off, c_off, op_base;
    logic        is_ctrl, is_stat, is_a, is_b, is_c;
    logic        wr_en, rd_en, start_acc, done_clr, op_wr_ok, last_elem;
    logic [EW-1:0] a_idx, b_idx, c_idx;
    logic        unused_addr;

    // Wrapping signed multiply-accumulate: 8x8 -> 16-bit product, mod 2^32 sum.
    function automatic logic signed [31:0] mac_step(input logic signed [31:0] acc,
                                                    input logic signed [7:0]  a,
                                                    input logic signed [7:0]  b);
        logic signed [15:0] prod;
        prod = a * b;
        return acc + {{16{prod[15]}}, prod};
    endfunction

    assign unused_addr = ^addr_i[1:0];
    assign wa      = 32'(addr_i[ADDR_WIDTH-1:2]);
    assign a_off   = wa - A_BASE;
    assign b_off   = wa - B_BASE;
    assign c_off   = wa - C_BASE;
    assign is_ctrl = (wa == 32'd0);
    assign is_stat = (wa == 32'd1);
    assign is_a    = (wa >= A_BASE) && (wa < A_BASE + 32'(NW));
    assign is_b    = (wa >= B_BASE) && (wa < B_BASE + 32'(NW));
    assign is_c    = (wa >= C_BASE) && (wa < C_BASE + 32'(NN));
    assign op_base = (is_a ? a_off : b_off) << 2;

    assign wr_en     = en_i & we_i;
    assign rd_en     = en_i & ~we_i;
    assign start_acc = wr_en & is_ctrl & be_i[0] & wdata_i[0] & (state_q == S_IDLE);
    assign done_clr  = wr_en & is_stat & be_i[0] & wdata_i[1];
    // Operands are frozen for the whole job, including the DONE cycle.
    assign op_wr_ok  = wr_en & (state_q == S_IDLE);
    assign last_elem = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));

    assign a_idx = EW'(32'(i_q) * N + 32'(k_q));
    assign b_idx = EW'(32'(k_q) * N + 32'(j_q));
    assign c_idx = EW'(32'(i_q) * N + 32'(j_q));

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                done_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            if (rd_en) begin
                rdata_q <= rd_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_CLR;
            S_CLR: begin
                busy    = 1'b1;
                state_d = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (k_q == IW'(N - 1)) state_d = S_STORE;
            end
            S_STORE: begin
                busy    = 1'b1;
                state_d = last_elem ? S_DONE : S_CLR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_acc) begin
                    i_q <= '0;
                    j_q <= '0;
                end
                S_CLR: begin
                    acc_q <= '0;
                    k_q   <= '0;
                end
                S_MAC: begin
                    acc_q <= mac_step(acc_q, a_mem[a_idx], b_mem[b_idx]);
                    k_q   <= k_q + 1'b1;
                end
                S_STORE: begin
                    if (j_q == IW'(N - 1)) begin
                        j_q <= '0;
                        i_q <= (i_q == IW'(N - 1)) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
        end else begin
            if (op_wr_ok && (is_a || is_b)) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be_i[b] && (op_base + 32'(b) < 32'(NN))) begin
                        if (is_a) a_mem[EW'(op_base + 32'(b))] <= wdata_i[8*b +: 8];
                        else      b_mem[EW'(op_base + 32'(b))] <= wdata_i[8*b +: 8];
                    end
                end
            end
            if (state_q == S_STORE) begin
                c_mem[c_idx] <= acc_q;
            end
        end
    end

`ifdef ACC_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && is_ctrl && be_i[0]) irq_en_q <= wdata_i[1];
            irq_q <= done_q & irq_en_q;
        end
    end

    assign ctrl_rd = {{(DATA_WIDTH-2){1'b0}}, irq_en_q, 1'b0};
    assign irq_o   = irq_q;
`else
    assign ctrl_rd = '0;
`endif

    always_comb begin
        rd_next = '0;
        if (is_ctrl) begin
            rd_next = ctrl_rd;
        end else if (is_stat) begin
            rd_next[1:0] = {done_q, busy};
        end else if (is_a || is_b) begin
            for (int b = 0; b < BYTES; b++) begin
                if (op_base + 32'(b) < 32'(NN)) begin
                    rd_next[8*b +: 8] = is_a ? a_mem[EW'(op_base + 32'(b))]
                                             : b_mem[EW'(op_base + 32'(b))];
                end
            end
        end else if (is_c) begin
            rd_next = c_mem[EW'(c_off)];
        end
    end

    assign rdata_o = rdata_q;
    assign busy_o  = busy;
    assign done_o  = done_q;

endmodule

// File: tb/tb_mat_acc_core.sv
// Randomised bench for mat_acc_core: bus tasks, a plain-arithmetic matrix model, per-scenario checks.
module tb_mat_acc_core;

    localparam int N  = 4;
    localparam int NN = N * N;
    localparam int NW = (NN + 3) / 4;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        en_i = 1'b0;
    logic        we_i = 1'b0;
    logic [10:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] rdata_o;
    logic        busy_o, done_o;
`ifdef ACC_IRQ_EN
    logic        irq_o;
`endif

    int  n_checks = 0;
    int  n_fail = 0;
    byte ma [NN];
    byte mb [NN];
    int  mc [NN];

    mat_acc_core #(.N(N), .ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn_i(rstn_i), .en_i(en_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .we_i(we_i), .be_i(be_i), .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o)
`ifdef ACC_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
        @(posedge clk); #1;
        en_i = 1'b0; we_i = 1'b0; be_i = '0;
    endtask

    task automatic bus_read(input logic [10:0] a, output logic [31:0] d);
        en_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(posedge clk); #1;
        en_i = 1'b0;
        d = rdata_o;
    endtask

    function automatic logic [31:0] pack_word(input int w, input bit use_b);
        logic [31:0] v = '0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < NN) v[8*b +: 8] = use_b ? mb[4*w+b] : ma[4*w+b];
        return v;
    endfunction

    // C = A x B using ordinary integer arithmetic (32-bit int wraps like the hardware).
    function automatic void model_c();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) s += int'(ma[i*N+k]) * int'(mb[k*N+j]);
                mc[i*N+j] = s;
            end
    endfunction

    task automatic load_ops();
        for (int w = 0; w < NW; w++) begin
            bus_write(11'(32'h100 + 4 * w), pack_word(w, 1'b0), 4'hF);
            bus_write(11'(32'h200 + 4 * w), pack_word(w, 1'b1), 4'hF);
        end
        model_c();
    endtask

    task automatic randomize_ops();
        for (int e = 0; e < NN; e++) begin
            ma[e] = byte'($urandom);
            mb[e] = byte'($urandom);
        end
    endtask

    task automatic wait_done(input int n0, output int done_at, output int busy_cnt);
        int n = n0;
        busy_cnt = 0;
        done_at  = -1;
        while (n < 400) begin
            if (done_o === 1'b1) begin
                done_at = n;
                break;
            end
            if (busy_o === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [10:0] regs [4] = '{11'h000, 11'h004, 11'h100, 11'h400};
        do_reset();
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy_o, done_o); end
`ifdef ACC_IRQ_EN
        n_checks++; if (irq_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_irq: got %b expected 0", irq_o); end
`endif
        for (int r = 0; r < 4; r++) begin
            bus_read(regs[r], rd);
            n_checks++; if (rd !== 32'h0) begin n_fail++;
                $display("FAIL reset_read[%h]: got %h expected 00000000", regs[r], rd); end
        end
    endtask

    task automatic test_identity();
        logic [31:0] rd;
        int done_at, busy_cnt;
        for (int e = 0; e < NN; e++) begin
            ma[e] = (e / N == e % N) ? 8'sd1 : 8'sd0;
            mb[e] = byte'(e + 1);
        end
        load_ops();
        bus_write(11'h000, 32'h1, 4'hF);
        wait_done(0, done_at, busy_cnt);
        n_checks++; if (done_at !== 97) begin n_fail++;
            $display("FAIL identity_latency: got %0d expected 97", done_at); end
        n_checks++; if (busy_cnt !== 96) begin n_fail++;
            $display("FAIL identity_busy_cycles: got %0d expected 96", busy_cnt); end
        bus_read(11'h004, rd);
        n_checks++; if (rd !== 32'h2) begin n_fail++;
            $display("FAIL identity_status: got %h expected 00000002", rd); end
        for (int e = 0; e < NN; e++) begin
            bus_read(11'(32'h400 + 4 * e), rd);
            n_checks++; if (rd !== 32'(e + 1)) begin n_fail++;
                $display("FAIL identity_c[%0d]: got %h expected %h", e, rd, 32'(e + 1)); end
        end
        bus_read(11'h414, rd);
        n_checks++; if (rd !== 32'd6) begin n_fail++;
            $display("FAIL identity_c5: got %h expected 00000006", rd); end
    endtask

    task automatic test_signed_wrap();
        logic [31:0] rd;
        logic [31:0] want [2] = '{32'h0001_0000, 32'hFFFF_0200};
        byte         bval [2] = '{-8'sd128, 8'sd127};
        int done_at, busy_cnt;
        for (int p = 0; p < 2; p++) begin
            for (int e = 0; e < NN; e++) begin
                ma[e] = -8'sd128;
                mb[e] = bval[p];
            end
            load_ops();
            bus_write(11'h000, 32'h1, 4'hF);
            wait_done(0, done_at, busy_cnt);
            n_checks++; if (done_at !== 97) begin n_fail++;
                $display("FAIL signed_latency[%0d]: got %0d expected 97", p, done_at); end
            for (int e = 0; e < NN; e++) begin
                bus_read(11'(32'h400 + 4 * e), rd);
                n_checks++; if (rd !== want[p]) begin n_fail++;
                    $display("FAIL signed_c[%0d][%0d]: got %h expected %h", p, e, rd, want[p]); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        int done_at, busy_cnt;
        for (int it = 0; it < 3; it++) begin
            randomize_ops();
            load_ops();
            bus_write(11'h000, 32'h1, 4'hF);
            wait_done(0, done_at, busy_cnt);
            n_checks++; if (done_at !== 97) begin n_fail++;
                $display("FAIL random_latency[%0d]: got %0d expected 97", it, done_at); end
            for (int e = 0; e < NN; e++) begin
                bus_read(11'(32'h400 + 4 * e), rd);
                n_checks++; if (rd !== 32'(mc[e])) begin n_fail++;
                    $display("FAIL random_c[%0d][%0d]: got %h expected %h", it, e, rd, 32'(mc[e])); end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        int done_at, busy_cnt;
        randomize_ops();
        load_ops();
        bus_write(11'h000, 32'h1, 4'hF);
        repeat (9) begin @(posedge clk); #1; end
        bus_write(11'h100, 32'hFFFF_FFFF, 4'hF);
        bus_write(11'h000, 32'h1, 4'hF);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++;
            $display("FAIL collision_busy: got %b expected 1", busy_o); end
        wait_done(11, done_at, busy_cnt);
        n_checks++; if (done_at !== 97) begin n_fail++;
            $display("FAIL collision_latency: got %0d expected 97", done_at); end
        for (int e = 0; e < NN; e++) begin
            bus_read(11'(32'h400 + 4 * e), rd);
            n_checks++; if (rd !== 32'(mc[e])) begin n_fail++;
                $display("FAIL collision_c[%0d]: got %h expected %h", e, rd, 32'(mc[e])); end
        end
        bus_read(11'h100, rd);
        n_checks++; if (rd !== pack_word(0, 1'b0)) begin n_fail++;
            $display("FAIL collision_a0: got %h expected %h", rd, pack_word(0, 1'b0)); end
        bus_write(11'h004, 32'h1, 4'hF);
        n_checks++; if (done_o !== 1'b1) begin n_fail++;
            $display("FAIL status_bit0_w: done=%b expected 1", done_o); end
        bus_write(11'h000, 32'h1, 4'hF);
        n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin n_fail++;
            $display("FAIL start_clears_done: busy=%b done=%b expected 1 0", busy_o, done_o); end
        bus_write(11'h004, 32'h2, 4'hF);
        n_checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin n_fail++;
            $display("FAIL start_w1c: busy=%b done=%b expected 1 0", busy_o, done_o); end
        wait_done(1, done_at, busy_cnt);
        n_checks++; if (done_at !== 97) begin n_fail++;
            $display("FAIL restart_latency: got %0d expected 97", done_at); end
        bus_write(11'h004, 32'h2, 4'hF);
        n_checks++; if (done_o !== 1'b0) begin n_fail++;
            $display("FAIL done_w1c: got %b expected 0", done_o); end
    endtask

    task automatic test_map();
        logic [31:0] rd;
        logic [10:0] zeros [4] = '{11'h0F0, 11'h300, 11'h110, 11'h440};
        bus_write(11'h100, 32'h0, 4'hF);
        bus_write(11'h100, 32'hAABB_CCDD, 4'b0101);
        bus_read(11'h100, rd);
        n_checks++; if (rd !== 32'h00BB_00DD) begin n_fail++;
            $display("FAIL be_a0: got %h expected 00bb00dd", rd); end
        bus_write(11'h204, 32'h0, 4'hF);
        bus_write(11'h204, 32'h1122_3344, 4'b1010);
        bus_read(11'h204, rd);
        n_checks++; if (rd !== 32'h1100_3300) begin n_fail++;
            $display("FAIL be_b1: got %h expected 11003300", rd); end
        bus_write(11'h400, 32'h1234_5678, 4'hF);
        bus_read(11'h400, rd);
        n_checks++; if (rd !== 32'(mc[0])) begin n_fail++;
            $display("FAIL c_write_ignored: got %h expected %h", rd, 32'(mc[0])); end
        bus_write(11'h0F0, 32'hDEAD_BEEF, 4'hF);
        for (int r = 0; r < 4; r++) begin
            bus_read(zeros[r], rd);
            n_checks++; if (rd !== 32'h0) begin n_fail++;
                $display("FAIL unmapped[%h]: got %h expected 00000000", zeros[r], rd); end
        end
        bus_write(11'h000, 32'h2, 4'hF);
        bus_read(11'h000, rd);
`ifdef ACC_IRQ_EN
        n_checks++; if (rd !== 32'h2) begin n_fail++;
            $display("FAIL ctrl_irq_en: got %h expected 00000002", rd); end
`else
        n_checks++; if (rd !== 32'h0) begin n_fail++;
            $display("FAIL ctrl_irq_en: got %h expected 00000000", rd); end
`endif
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL ctrl_no_start: busy=%b expected 0", busy_o); end
        bus_write(11'h000, 32'h0, 4'hF);
    endtask

    task automatic test_abort_irq();
        logic [31:0] rd;
        logic [10:0] regs [4] = '{11'h000, 11'h004, 11'h100, 11'h400};
        int done_at, busy_cnt;
        randomize_ops();
        load_ops();
        bus_write(11'h000, 32'h3, 4'hF);
        repeat (39) begin @(posedge clk); #1; end
        rstn_i = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++;
            $display("FAIL abort_flags: busy=%b done=%b expected 0 0", busy_o, done_o); end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (70) begin @(posedge clk); #1; end
        n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
            $display("FAIL abort_no_done: busy=%b done=%b expected 0 0", busy_o, done_o); end
`ifdef ACC_IRQ_EN
        n_checks++; if (irq_o !== 1'b0) begin n_fail++;
            $display("FAIL abort_irq: got %b expected 0", irq_o); end
`endif
        for (int r = 0; r < 4; r++) begin
            bus_read(regs[r], rd);
            n_checks++; if (rd !== 32'h0) begin n_fail++;
                $display("FAIL abort_read[%h]: got %h expected 00000000", regs[r], rd); end
        end
        load_ops();
        bus_write(11'h000, 32'h3, 4'hF);
        wait_done(0, done_at, busy_cnt);
        n_checks++; if (done_at !== 97) begin n_fail++;
            $display("FAIL rerun_latency: got %0d expected 97", done_at); end
`ifdef ACC_IRQ_EN
        n_checks++; if (irq_o !== 1'b0) begin n_fail++;
            $display("FAIL irq_early: got %b expected 0", irq_o); end
        @(posedge clk); #1;
        n_checks++; if (irq_o !== 1'b1) begin n_fail++;
            $display("FAIL irq_rise: got %b expected 1", irq_o); end
`endif
        bus_write(11'h004, 32'h2, 4'hF);
        n_checks++; if (done_o !== 1'b0) begin n_fail++;
            $display("FAIL rerun_w1c: got %b expected 0", done_o); end
`ifdef ACC_IRQ_EN
        n_checks++; if (irq_o !== 1'b1) begin n_fail++;
            $display("FAIL irq_hold: got %b expected 1", irq_o); end
        @(posedge clk); #1;
        n_checks++; if (irq_o !== 1'b0) begin n_fail++;
            $display("FAIL irq_fall: got %b expected 0", irq_o); end
`endif
        for (int e = 0; e < NN; e++) begin
            bus_read(11'(32'h400 + 4 * e), rd);
            n_checks++; if (rd !== 32'(mc[e])) begin n_fail++;
                $display("FAIL rerun_c[%0d]: got %h expected %h", e, rd, 32'(mc[e])); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed_wrap();
        test_random();
        test_collision();
        test_map();
        test_abort_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
